// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared flag encodings and FSM state type for pc_sequencer
package pc_sequencer_pkg;

    localparam logic [2:0] PC_HOLD     = 3'd0;
    localparam logic [2:0] PC_INC      = 3'd1;
    localparam logic [2:0] PC_JUMP     = 3'd2;
    localparam logic [2:0] PC_DELAY    = 3'd3;
    localparam logic [2:0] PC_END_BIOS = 3'd4;
    localparam logic [2:0] PC_EXEC     = 3'd5;

    localparam logic [2:0] UPD_NONE    = 3'd0;
    localparam logic [2:0] UPD_QUANTUM = 3'd1;
    localparam logic [2:0] UPD_CS      = 3'd2;
    localparam logic [2:0] UPD_SAVEDPC = 3'd3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DELAY   = 2'd1,
        ST_PREEMPT = 2'd2
    } seqState_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control-unit <-> pc_sequencer bus; PC_BOUND_CHECK_EN adds pc_limit/pc_fault
interface pc_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [2:0]        flagPC;
    logic              flagJR;
    logic              flagMP;
    logic [2:0]        flagUpdateData;
    logic [ADDR_W-1:0] imm_target;
    logic [DATA_W-1:0] reg_target;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] pc;
    logic              bios_done;
    logic [DATA_W-1:0] saved_pc;
    logic              interruption;
    logic              busy;
`ifdef PC_BOUND_CHECK_EN
    logic [ADDR_W-1:0] pc_limit;
    logic              pc_fault;

    modport master (
        output flagPC, flagJR, flagMP, flagUpdateData, imm_target, reg_target, data_in, pc_limit,
        input  pc, bios_done, saved_pc, interruption, busy, pc_fault
    );
    modport slave (
        input  flagPC, flagJR, flagMP, flagUpdateData, imm_target, reg_target, data_in, pc_limit,
        output pc, bios_done, saved_pc, interruption, busy, pc_fault
    );
`else
    modport master (
        output flagPC, flagJR, flagMP, flagUpdateData, imm_target, reg_target, data_in,
        input  pc, bios_done, saved_pc, interruption, busy
    );
    modport slave (
        input  flagPC, flagJR, flagMP, flagUpdateData, imm_target, reg_target, data_in,
        output pc, bios_done, saved_pc, interruption, busy
    );
`endif
endinterface

// File: rtl/pc_sequencer_quantum_timer.sv
// rtl/pc_sequencer_quantum_timer.sv - round-robin quantum counter; expire marks the last advancing instruction
module pc_sequencer_quantum_timer #(
    parameter int QUANT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               loadQuantum,
    input  logic [QUANT_W-1:0] quantumIn,
    input  logic               arm,
    input  logic               launch,
    input  logic               clear,
    input  logic               advance,
    output logic               expire
);
    logic [QUANT_W-1:0] quantum;
    logic [QUANT_W-1:0] qcount;
    logic               mpActive;
    logic               enabled;
    logic               counting;

    // A zero quantum means preemption is off, even if already armed.
    assign enabled  = (quantum != '0);
    assign counting = mpActive && enabled && advance;
    assign expire   = counting && (qcount == quantum - 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quantum  <= '0;
            qcount   <= '0;
            mpActive <= 1'b0;
        end else begin
            if (loadQuantum)
                quantum <= quantumIn;

            if (clear || expire)
                qcount <= '0;
            else if (counting)
                qcount <= qcount + 1'b1;

            if (expire)
                mpActive <= 1'b0;
            else if ((arm || launch) && enabled)
                mpActive <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter stage with delay, BIOS hand-off and quantum preemption
// Optional PC_BOUND_CHECK_EN: sticky pc_fault freezes pc once a step reaches pc_limit after BIOS.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int QUANT_W      = 16,
    parameter int DELAY_CYCLES = 50
) (
    input logic            clock,
    input logic            reset,
    pc_sequencer_if.slave  sif
);
    localparam int DCNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    seqState_t         state;
    logic [DCNT_W-1:0] dcount;
    logic [ADDR_W-1:0] nextPc;
    logic              advance;
    logic              launch;
    logic              bootEnd;
    logic              delayDone;
    logic              frozen;
    logic              expire;
    logic              unusedRegHigh;

    assign unusedRegHigh = ^sif.reg_target[DATA_W-1:ADDR_W];
    assign delayDone     = (state == ST_DELAY) && (dcount == '0);

    always_comb begin
        nextPc  = sif.pc;
        advance = 1'b0;
        launch  = 1'b0;
        bootEnd = 1'b0;
        if (state == ST_RUN) begin
            case (sif.flagPC)
                PC_HOLD, PC_DELAY: nextPc = sif.pc;
                PC_INC: begin
                    nextPc  = sif.pc + 1'b1;
                    advance = 1'b1;
                end
                PC_JUMP: begin
                    nextPc  = sif.flagJR ? sif.reg_target[ADDR_W-1:0] : sif.imm_target;
                    advance = 1'b1;
                end
                PC_END_BIOS: begin
                    nextPc  = '0;
                    bootEnd = 1'b1;
                end
                PC_EXEC: begin
                    nextPc = sif.data_in[ADDR_W-1:0];
                    launch = 1'b1;
                end
                default: nextPc = sif.pc;
            endcase
        end else if (delayDone) begin
            nextPc = sif.pc + 1'b1;
        end
    end

`ifdef PC_BOUND_CHECK_EN
    logic boundHit;
    // Only stepping moves are policed; BIOS end and process launch are exempt.
    assign boundHit = sif.bios_done && (advance || delayDone) && (nextPc >= sif.pc_limit);
    assign frozen   = sif.pc_fault || boundHit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sif.pc_fault <= 1'b0;
        else if (boundHit)
            sif.pc_fault <= 1'b1;
    end
`else
    assign frozen = 1'b0;
`endif

    logic [ADDR_W-1:0] csAddr;

    pc_sequencer_quantum_timer #(.QUANT_W(QUANT_W)) u_quantum_timer (
        .clock       (clock),
        .reset       (reset),
        .loadQuantum (sif.flagUpdateData == UPD_QUANTUM),
        .quantumIn   (sif.data_in[QUANT_W-1:0]),
        .arm         (sif.flagMP),
        .launch      (launch),
        .clear       (launch || bootEnd),
        .advance     (advance && !frozen),
        .expire      (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_RUN;
            dcount           <= '0;
            csAddr           <= '0;
            sif.pc           <= '0;
            sif.bios_done    <= 1'b0;
            sif.saved_pc     <= '0;
            sif.interruption <= 1'b0;
            sif.busy         <= 1'b0;
        end else begin
            sif.interruption <= 1'b0;
            if (sif.flagUpdateData == UPD_CS)
                csAddr <= sif.data_in[ADDR_W-1:0];
            // Written before the FSM so a same-edge preemption overrides it.
            if (sif.flagUpdateData == UPD_SAVEDPC)
                sif.saved_pc <= sif.data_in;

            case (state)
                ST_RUN: begin
                    if (expire) begin
                        sif.saved_pc     <= DATA_W'(nextPc);
                        sif.pc           <= csAddr;
                        sif.interruption <= 1'b1;
                        state            <= ST_PREEMPT;
                    end else if (!frozen) begin
                        sif.pc <= nextPc;
                    end
                    if (bootEnd)
                        sif.bios_done <= 1'b1;
                    if (sif.flagPC == PC_DELAY) begin
                        dcount   <= DCNT_W'(DELAY_CYCLES - 1);
                        sif.busy <= 1'b1;
                        state    <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (delayDone) begin
                        if (!frozen)
                            sif.pc <= nextPc;
                        sif.busy <= 1'b0;
                        state    <= ST_RUN;
                    end else begin
                        dcount <= dcount - 1'b1;
                    end
                end
                ST_PREEMPT: state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer (DELAY_CYCLES=4)
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clock;
    logic reset;
    int   nCompared;
    int   nMismatched;
    int   pulseCount;

    pc_sequencer_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W(10), .DATA_W(32), .QUANT_W(16), .DELAY_CYCLES(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sif   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] pcFlag, input logic [2:0] upd, input logic [31:0] din);
        bus.flagPC         = pcFlag;
        bus.flagUpdateData = upd;
        bus.data_in        = din;
    endtask

    task automatic jumpImm(input logic [9:0] target);
        bus.flagJR     = 1'b0;
        bus.imm_target = target;
        drive(PC_JUMP, UPD_NONE, 32'd0);
        tick();
        drive(PC_HOLD, UPD_NONE, 32'd0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b1;
        bus.flagJR  = 1'b0;
        bus.flagMP  = 1'b0;
        bus.imm_target = '0;
        bus.reg_target = '0;
        drive(PC_HOLD, UPD_NONE, 32'd0);
`ifdef PC_BOUND_CHECK_EN
        bus.pc_limit = 10'h3FF;
`endif
        #12;
        checkVal("rst_pc", 32'(bus.pc), 32'd0);
        checkVal("rst_bios", 32'(bus.bios_done), 32'd0);
        checkVal("rst_saved", bus.saved_pc, 32'd0);
        checkVal("rst_intr", 32'(bus.interruption), 32'd0);
        checkVal("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();

        // Increment then register jump
        jumpImm(10'd5);
        checkVal("jmp_imm", 32'(bus.pc), 32'd5);
        for (int i = 0; i < 3; i++) begin
            drive(PC_INC, UPD_NONE, 32'd0);
            tick();
            checkVal("inc", 32'(bus.pc), 32'(6 + i));
        end
        bus.flagJR     = 1'b1;
        bus.reg_target = 32'h0000_0123;
        bus.imm_target = 10'h055;
        drive(PC_JUMP, UPD_NONE, 32'd0);
        tick();
        checkVal("jmp_reg", 32'(bus.pc), 32'h123);

        // Delay: 4 hold cycles, flagPC ignored meanwhile
        jumpImm(10'd20);
        drive(PC_DELAY, UPD_NONE, 32'd0);
        tick();
        drive(PC_INC, UPD_NONE, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkVal("dly_pc", 32'(bus.pc), 32'd20);
            checkVal("dly_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        checkVal("dly_end_pc", 32'(bus.pc), 32'd21);
        checkVal("dly_end_busy", 32'(bus.busy), 32'd0);
        drive(PC_HOLD, UPD_NONE, 32'd0);

        // Reset mid-delay
        drive(PC_DELAY, UPD_NONE, 32'd0);
        tick();
        drive(PC_HOLD, UPD_NONE, 32'd0);
        tick();
        reset = 1'b1;
        #2;
        checkVal("mrst_pc", 32'(bus.pc), 32'd0);
        checkVal("mrst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();
        drive(PC_INC, UPD_NONE, 32'd0);
        tick();
        checkVal("mrst_run_pc", 32'(bus.pc), 32'd1);
        checkVal("mrst_run_busy", 32'(bus.busy), 32'd0);

        // Preemption with quantum 3
        drive(PC_HOLD, UPD_QUANTUM, 32'd3);
        tick();
        drive(PC_HOLD, UPD_CS, 32'd100);
        tick();
        drive(PC_EXEC, UPD_NONE, 32'd40);
        tick();
        checkVal("exec_pc", 32'(bus.pc), 32'd40);
        drive(PC_INC, UPD_NONE, 32'd0);
        tick();
        checkVal("q_pc1", 32'(bus.pc), 32'd41);
        tick();
        checkVal("q_pc2", 32'(bus.pc), 32'd42);
        checkVal("q_intr_pre", 32'(bus.interruption), 32'd0);
        tick();
        checkVal("pre_pc", 32'(bus.pc), 32'd100);
        checkVal("pre_saved", bus.saved_pc, 32'd43);
        checkVal("pre_intr", 32'(bus.interruption), 32'd1);
        tick();
        checkVal("pre_hold_pc", 32'(bus.pc), 32'd100);
        checkVal("pre_intr_off", 32'(bus.interruption), 32'd0);
        pulseCount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.interruption) pulseCount++;
        end
        checkVal("os_pc", 32'(bus.pc), 32'd105);
        checkVal("no_2nd_pulse", 32'(pulseCount), 32'd0);

        // Preemption beats a same-edge saved_pc load
        drive(PC_EXEC, UPD_NONE, 32'd200);
        tick();
        drive(PC_INC, UPD_NONE, 32'd0);
        tick();
        tick();
        checkVal("q2_pc", 32'(bus.pc), 32'd202);
        drive(PC_INC, UPD_SAVEDPC, 32'hDEAD_BEEF);
        tick();
        checkVal("q2_pre_pc", 32'(bus.pc), 32'd100);
        checkVal("q2_saved_wins", bus.saved_pc, 32'd203);
        drive(PC_HOLD, UPD_SAVEDPC, 32'hABCD_0001);
        tick();
        checkVal("saved_load", bus.saved_pc, 32'hABCD_0001);

        // Quantum 0 disables preemption
        drive(PC_HOLD, UPD_QUANTUM, 32'd0);
        tick();
        drive(PC_EXEC, UPD_NONE, 32'd10);
        tick();
        drive(PC_INC, UPD_NONE, 32'd0);
        pulseCount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.interruption) pulseCount++;
        end
        checkVal("q0_pc", 32'(bus.pc), 32'd14);
        checkVal("q0_no_pulse", 32'(pulseCount), 32'd0);

        // BIOS hand-off
        jumpImm(10'd300);
        checkVal("bios_pre_pc", 32'(bus.pc), 32'd300);
        drive(PC_END_BIOS, UPD_NONE, 32'd0);
        tick();
        checkVal("bios_pc", 32'(bus.pc), 32'd0);
        checkVal("bios_done", 32'(bus.bios_done), 32'd1);
        jumpImm(10'd50);
        checkVal("bios_sticky_pc", 32'(bus.pc), 32'd50);
        checkVal("bios_sticky", 32'(bus.bios_done), 32'd1);

`ifdef PC_BOUND_CHECK_EN
        bus.pc_limit = 10'd64;
        jumpImm(10'd63);
        checkVal("bnd_pre_fault", 32'(bus.pc_fault), 32'd0);
        drive(PC_INC, UPD_NONE, 32'd0);
        tick();
        checkVal("bnd_fault", 32'(bus.pc_fault), 32'd1);
        checkVal("bnd_pc", 32'(bus.pc), 32'd63);
        tick();
        checkVal("bnd_pc_hold", 32'(bus.pc), 32'd63);
        drive(PC_HOLD, UPD_NONE, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
